// File: rtl/smvm_pkg.sv
// smvm_pkg: shared types and helpers for the sparse matrix x vector feed controller.
//   state_t      - sequencing states of the feed FSM
//   lane_mode_t  - what the lane packer loads on the next clock
//   lane_t       - one COO nonzero as carried on a datapath lane
//   sentinel_row - row id that drives the datapath into DONE
//   ceil_div     - beat count from a nonzero count
package smvm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    FETCH     = 3'd2,
    DRAIN     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    LANE_IDLE     = 2'd0,
    LANE_DATA     = 2'd1,
    LANE_SENTINEL = 2'd2
  } lane_mode_t;

  typedef struct packed {
    logic [31:0] value;
    logic [31:0] col;
    logic [31:0] row;
  } lane_t;

  function automatic logic [31:0] sentinel_row(input int unsigned matrix_size);
    return 32'(matrix_size);
  endfunction

  // Written as quotient plus remainder test so nnz near 2^32 cannot wrap.
  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    logic [31:0] q;
    q = num / den;
    if ((num % den) != 32'd0) q = q + 32'd1;
    return q;
  endfunction

endpackage

// File: rtl/smvm_feed_controller_lane_packer.sv
// smvm_lane_packer: output register stage for the datapath lanes.
//   clk, rst_l                    - clock, async active-low reset
//   mode                          - IDLE (row 0), DATA (load bank words), SENTINEL (row=MATRIX_SIZE)
//   last, last_mask               - current DATA beat is the final one; lanes valid in it
//   mem_value/mem_col/mem_row     - bank read data, one word per lane
//   values/col_id/row_id, rdy     - registered lane outputs to the datapath
module smvm_lane_packer
  import smvm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int MATRIX_SIZE  = 128
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  lane_mode_t                    mode,
  input  logic                          last,
  input  logic [NUM_CHANNELS-1:0]       last_mask,
  input  logic [NUM_CHANNELS-1:0][31:0] mem_value,
  input  logic [NUM_CHANNELS-1:0][31:0] mem_col,
  input  logic [NUM_CHANNELS-1:0][31:0] mem_row,
  output logic [NUM_CHANNELS-1:0][31:0] values,
  output logic [NUM_CHANNELS-1:0][31:0] col_id,
  output logic [NUM_CHANNELS-1:0][31:0] row_id,
  output logic                          rdy
);

  lane_t [NUM_CHANNELS-1:0] lane_d;
  lane_t [NUM_CHANNELS-1:0] lane_q;

  always_comb begin
    lane_d = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      case (mode)
        LANE_DATA: begin
          // Padded lanes of the final beat carry a zero product into the sentinel row.
          if (!last || last_mask[k])
            lane_d[k] = '{value: mem_value[k], col: mem_col[k], row: mem_row[k]};
          else
            lane_d[k] = '{value: 32'd0, col: 32'd0, row: sentinel_row(MATRIX_SIZE)};
        end
        LANE_SENTINEL: lane_d[k] = '{value: 32'd0, col: 32'd0, row: sentinel_row(MATRIX_SIZE)};
        default:       lane_d[k] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lane_q <= '0;
      rdy    <= 1'b0;
    end else begin
      lane_q <= lane_d;
      rdy    <= (mode == LANE_DATA);
    end
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    assign values[k] = lane_q[k].value;
    assign col_id[k] = lane_q[k].col;
    assign row_id[k] = lane_q[k].row;
  end

endmodule

// File: rtl/smvm_feed_controller.sv
// smvm_feed_controller: sequences one sparse matrix x vector run into the 4-lane datapath.
//   clk, rst_l                 - clock, async active-low reset
//   start, nnz                 - host run request (accepted in IDLE only) and nonzero count
//   busy, done, error          - run in progress, completion pulse, sticky timeout flag
//   cycle_count                - cycles from accepted start to done/error (saturating)
//   mem_addr, mem_rd           - common bank word address and read strobe (data 1 cycle later)
//   mem_value/mem_col/mem_row  - bank read data
//   dp_rst_l                   - registered active-low datapath clear
//   values/col_id/row_id, rdy  - lane outputs to the datapath
//   dp_done                    - datapath finished
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lanes row 0 / rdy 0, waiting for start
// CLEAR     | dp_rst_l low for DP_RST_CYCLES cycles
// FETCH     | mem_rd high, addresses 0..beats-1 back to back
// DRAIN     | last beats leave the pipeline, then sentinel flood begins
// WAIT_DONE | sentinel held, waiting for dp_done or timeout
module smvm_feed_controller
  import smvm_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int MATRIX_SIZE   = 128,
  parameter int ADDR_W        = 10,
  parameter int DP_RST_CYCLES = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          start,
  input  logic [31:0]                   nnz,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [31:0]                   cycle_count,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_rd,
  input  logic [NUM_CHANNELS-1:0][31:0] mem_value,
  input  logic [NUM_CHANNELS-1:0][31:0] mem_col,
  input  logic [NUM_CHANNELS-1:0][31:0] mem_row,
  output logic                          dp_rst_l,
  output logic [NUM_CHANNELS-1:0][31:0] values,
  output logic [NUM_CHANNELS-1:0][31:0] col_id,
  output logic [NUM_CHANNELS-1:0][31:0] row_id,
  output logic                          rdy,
  input  logic                          dp_done
);

  localparam int          CLR_W     = $clog2(DP_RST_CYCLES + 1);
  localparam int          TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [31:0] MAX_BEATS = 32'd1 << ADDR_W;

  state_t                  state;
  logic [CLR_W-1:0]        clr_cnt;
  logic [TMR_W-1:0]        tmr;
  logic [ADDR_W-1:0]       last_addr;
  logic [NUM_CHANNELS-1:0] last_mask;
  logic                    beats_zero;
  logic                    rd_d1;
  logic                    last_d1;
  logic [31:0]             beats_raw;
  logic [31:0]             beats_clamp;
  logic [NUM_CHANNELS-1:0] mask_d;
  lane_mode_t              mode;

  always_comb begin
    beats_raw   = ceil_div(nnz, 32'(NUM_CHANNELS));
    beats_clamp = (beats_raw > MAX_BEATS) ? MAX_BEATS : beats_raw;
    mask_d      = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      mask_d[k] = (((beats_clamp - 32'd1) * 32'(NUM_CHANNELS)) + 32'(k)) < nnz;
  end

  // The exit cycle of WAIT_DONE already loads the idle pattern so lanes fall with busy.
  always_comb begin
    mode = LANE_IDLE;
    if (rd_d1)
      mode = LANE_DATA;
    else if (state == DRAIN || (state == WAIT_DONE && !dp_done && tmr != '0))
      mode = LANE_SENTINEL;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cycle_count <= 32'd0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      dp_rst_l    <= 1'b1;
      clr_cnt     <= '0;
      tmr         <= '0;
      last_addr   <= '0;
      last_mask   <= '0;
      beats_zero  <= 1'b0;
      rd_d1       <= 1'b0;
      last_d1     <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_d1   <= mem_rd;
      last_d1 <= mem_rd && (mem_addr == last_addr);
      if (busy && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;

      case (state)
        IDLE: begin
          if (start) begin
            beats_zero  <= (beats_clamp == 32'd0);
            last_addr   <= ADDR_W'(beats_clamp - 32'd1);
            last_mask   <= mask_d;
            cycle_count <= 32'd0;
            error       <= 1'b0;
            busy        <= 1'b1;
            dp_rst_l    <= 1'b0;
            clr_cnt     <= CLR_W'(DP_RST_CYCLES - 1);
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_cnt == '0) begin
            dp_rst_l <= 1'b1;
            if (beats_zero) begin
              state <= DRAIN;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= '0;
              state    <= FETCH;
            end
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end
        FETCH: begin
          if (mem_addr == last_addr) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            state    <= DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          // rd_d1 low means the final beat is already in the output flops.
          if (!rd_d1) begin
            tmr   <= TMR_W'(TIMEOUT - 1);
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (dp_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmr == '0) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  smvm_lane_packer #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .MATRIX_SIZE (MATRIX_SIZE)
  ) u_packer (
    .clk      (clk),
    .rst_l    (rst_l),
    .mode     (mode),
    .last     (last_d1),
    .last_mask(last_mask),
    .mem_value(mem_value),
    .mem_col  (mem_col),
    .mem_row  (mem_row),
    .values   (values),
    .col_id   (col_id),
    .row_id   (row_id),
    .rdy      (rdy)
  );

endmodule
